// File: rtl/led_tape_mc.sv
// Multi-channel WS281x-style LED string driver. Lockstep serial encoders.
// Optional brightness scaling: define LED_TAPE_MC_BRIGHT_EN.
module led_tape_mc #(
    parameter int NUM_CH         = 4,
    parameter int NUM_LEDS       = 60,
    parameter int NUM_RESET_LEDS = 4,
    parameter int BPP            = 24,
    parameter int T0H            = 4,
    parameter int T1H            = 8,
    parameter int TBIT           = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [NUM_CH*BPP-1:0] pixels,
`ifdef LED_TAPE_MC_BRIGHT_EN
    input  logic [7:0]            bright,
`endif
    output logic [NUM_CH-1:0]     data,
    output logic [15:0]           num,
    output logic                  sync,
    output logic                  req,
    output logic                  busy
);

    localparam int TOT = NUM_LEDS + NUM_RESET_LEDS;
    localparam int CW  = $clog2(TBIT);
    localparam int BW  = $clog2(BPP);
    localparam int SW  = (TOT > 1) ? $clog2(TOT) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRE,
        S_SLOT,
        S_GAP
    } state_t;

    state_t                       r_state;
    state_t                       w_state_nx;
    logic [CW-1:0]                r_cyc;
    logic [BW-1:0]                r_bit;
    logic [SW-1:0]                r_slot;
    logic [NUM_CH-1:0][BPP-1:0]   r_sh;
    logic [NUM_CH-1:0][BPP-1:0]   w_load;
    logic                         r_req;
    logic                         r_sync;
    logic                         r_busy;
    logic                         r_cont;
    logic [15:0]                  r_num;

    logic                         w_bit_end;
    logic                         w_slot_end;
    logic                         w_req_pt;
    logic                         w_last_data;
    logic                         w_last_gap;
    logic                         w_req_set;
    logic                         w_cont_nx;
    logic                         w_idle_go;
    logic                         w_sync_nx;
    logic [15:0]                  w_num_nx;
    logic [15:0]                  w_next_slot;

    assign w_bit_end   = (r_cyc == CW'(TBIT - 1));
    assign w_slot_end  = w_bit_end && (r_bit == BW'(BPP - 1));
    // one cycle before the last bit period of the slot starts
    assign w_req_pt    = w_bit_end && (r_bit == BW'(BPP - 2));
    assign w_last_data = (r_slot == SW'(NUM_LEDS - 1));
    assign w_last_gap  = (r_slot == SW'(TOT - 1));
    assign w_next_slot = 16'(r_slot) + 16'd1;

`ifdef LED_TAPE_MC_BRIGHT_EN
    function automatic logic [7:0] f_scale(
        input logic [7:0] i_c,
        input logic [7:0] i_b
    );
        logic [15:0] p;
        p = 16'(i_c) * (16'(i_b) + 16'd1);
        return 8'(p >> 8);
    endfunction

    always_comb begin
        w_load = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            for (int k = 0; k < BPP / 8; k++) begin
                w_load[c][k*8 +: 8] = f_scale(pixels[c*BPP + k*8 +: 8], bright);
            end
        end
    end
`else
    assign w_load = pixels;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        unique case (r_state)
            S_IDLE: if (en) w_state_nx = S_PRE;
            S_PRE:  if (w_bit_end) w_state_nx = S_SLOT;
            S_SLOT: if (w_slot_end && w_last_data) w_state_nx = S_GAP;
            S_GAP: begin
                if (w_slot_end && w_last_gap) begin
                    w_state_nx = r_cont ? S_SLOT : S_IDLE;
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        w_req_set = 1'b0;
        w_num_nx  = 16'd0;
        w_cont_nx = r_cont;
        w_idle_go = 1'b0;
        unique case (r_state)
            S_IDLE: w_req_set = en;
            S_SLOT, S_GAP: begin
                if (w_req_pt) begin
                    if (r_state == S_GAP && w_last_gap) begin
                        // frame boundary: en decides on a contiguous next frame
                        w_req_set = en;
                        w_cont_nx = en;
                    end else begin
                        w_req_set = 1'b1;
                        w_num_nx  = w_next_slot;
                    end
                end
                if (r_state == S_GAP && w_slot_end && w_last_gap && !r_cont) begin
                    w_idle_go = 1'b1;
                end
            end
            default: w_req_set = 1'b0;
        endcase
        w_sync_nx = (w_num_nx >= 16'(NUM_LEDS));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_req  <= 1'b0;
            r_num  <= 16'd0;
            r_sync <= 1'b0;
            r_busy <= 1'b0;
            r_cont <= 1'b0;
        end else begin
            r_req  <= w_req_set;
            r_cont <= w_cont_nx;
            if (w_req_set) begin
                r_num  <= w_num_nx;
                r_sync <= w_sync_nx;
            end else if (w_idle_go) begin
                r_num  <= 16'd0;
                r_sync <= 1'b0;
            end
            if (r_state == S_IDLE && en) begin
                r_busy <= 1'b1;
            end else if (w_idle_go) begin
                r_busy <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cyc  <= '0;
            r_bit  <= '0;
            r_slot <= '0;
            r_sh   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_cyc  <= '0;
                    r_bit  <= '0;
                    r_slot <= '0;
                end
                S_PRE: begin
                    if (w_bit_end) begin
                        r_cyc <= '0;
                        r_sh  <= w_load;
                    end else begin
                        r_cyc <= r_cyc + CW'(1);
                    end
                end
                default: begin
                    if (w_bit_end) begin
                        r_cyc <= '0;
                        if (r_bit == BW'(BPP - 1)) begin
                            r_bit  <= '0;
                            r_sh   <= w_load;
                            r_slot <= w_last_gap ? '0 : r_slot + SW'(1);
                        end else begin
                            r_bit <= r_bit + BW'(1);
                            for (int c = 0; c < NUM_CH; c++) begin
                                r_sh[c] <= {r_sh[c][BPP-2:0], 1'b0};
                            end
                        end
                    end else begin
                        r_cyc <= r_cyc + CW'(1);
                    end
                end
            endcase
        end
    end

    always_comb begin
        data = '0;
        if (r_state == S_SLOT) begin
            for (int c = 0; c < NUM_CH; c++) begin
                data[c] = r_sh[c][BPP-1] ? (r_cyc < CW'(T1H)) : (r_cyc < CW'(T0H));
            end
        end
    end

    assign num  = r_num;
    assign sync = r_sync;
    assign req  = r_req;
    assign busy = r_busy;

endmodule

// File: doc/led_tape_mc.md
LED_TAPE_MC -- requirements
Module: led_tape_mc

Interface
REQ-001 Parameter NUM_CH, default 4: number of parallel LED strings, each with its own data line.
REQ-002 Parameter NUM_LEDS, default 60: LED slots per frame, per channel.
REQ-003 Parameter NUM_RESET_LEDS, default 4: slot-length low periods appended after the data slots (latch gap).
REQ-004 Parameter BPP, default 24: bits per LED; 24 = GRB, 32 = GRBW; SHALL be a multiple of 8.
REQ-005 Parameters T0H (default 4), T1H (default 8), TBIT (default 12): clk cycles high for a 0 bit, high for a 1 bit, and full bit period; require 1 <= T0H < T1H < TBIT and TBIT >= 3.
REQ-006 clk  in  1  single clock; all logic on its rising edge.
REQ-007 rst  in  1  reset, asynchronous, active-high.
REQ-008 en  in  1  frame enable, sampled only at frame boundaries.
REQ-009 pixels  in  NUM_CH*BPP  pixel word; channel c occupies bits [c*BPP +: BPP], transmitted MSB first.
REQ-010 bright  in  8  global brightness; exists only with LED_TAPE_MC_BRIGHT_EN.
REQ-011 data  out  NUM_CH  serial data lines, one per channel.
REQ-012 num  out  16  index of the slot being requested: 0..NUM_LEDS+NUM_RESET_LEDS-1.
REQ-013 sync  out  1  high while num addresses a reset slot (num >= NUM_LEDS).
REQ-014 req  out  1  one-cycle pixel request strobe.
REQ-015 busy  out  1  high from the first req of a frame until the last reset slot ends.

Function
REQ-016 States IDLE, PRE, SLOT, GAP; IDLE -> PRE when en=1, PRE -> SLOT after TBIT cycles, SLOT -> GAP after NUM_LEDS slots, GAP -> SLOT (num=0) or IDLE after NUM_RESET_LEDS slots.
REQ-017 IDLE: data=0, req=0, busy=0, sync=0, num=0.
REQ-018 IDLE with en=1: req pulses with num=0, sync=0; PRE holds data low for TBIT cycles, then slot 0 begins.
REQ-019 Each slot is BPP bit periods; per bit, data is high for T1H (bit 1) or T0H (bit 0) cycles, then low until TBIT cycles.
REQ-020 req for slot k+1 SHALL pulse in the first cycle of the last bit period of slot k; num and sync update in that same cycle and hold until the next req.
REQ-021 pixels (and bright) SHALL be sampled into the per-channel shift registers in the last cycle before the requested slot starts, i.e. TBIT-1 cycles after its req.
REQ-022 All channels shift in lockstep; bit edges on all data lines coincide.
REQ-023 GAP slots: data=0 on all channels, req still pulses per slot with sync=1; sampled pixels are ignored.
REQ-024 In the last bit period of the last GAP slot, en is sampled at the req point: en=1 -> req with num=0, next frame contiguous (no PRE); en=0 -> no req, IDLE after the slot.
REQ-025 en changes mid-frame SHALL NOT affect the current frame.
REQ-026 Frame length from slot 0: (NUM_LEDS+NUM_RESET_LEDS)*BPP*TBIT cycles; counters sized by $clog2; NUM_LEDS+NUM_RESET_LEDS <= 65535.

Reset
REQ-027 rst=1 SHALL immediately force data=0, req=0, sync=0, busy=0, num=0, state IDLE, clear shift registers and counters, including mid-slot.
REQ-028 After rst release, the first req occurs no earlier than the first clk edge with en=1.

Configuration
REQ-029 With LED_TAPE_MC_BRIGHT_EN defined: each sampled byte c becomes (c*(bright+1))>>8, computed at the sample point (REQ-021), no added latency; bright=255 passes bytes unchanged.
REQ-030 Without LED_TAPE_MC_BRIGHT_EN: the bright port is absent and bytes are transmitted raw.

Verification (NUM_CH=2, NUM_LEDS=3, NUM_RESET_LEDS=2, BPP=24, T0H=3, T1H=6, TBIT=10)
REQ-031 en=1 after reset, bench answers req with num-coded pixels as in the existing LED_tape bench -> PRE of 10 low cycles, then 1200-cycle frame, req at num 0..4, sync=1 for num 3,4.
REQ-032 Channel 0 pixel 24'hFF0000, channel 1 pixel 24'h000001 -> ch0 first 8 bits high for 6 cycles and next 16 high for 3 cycles; ch1 23 bits of 3-cycle highs, last bit 6-cycle high.
REQ-033 en held 1 -> frames back-to-back, req num=0 exactly 10 cycles before the next slot 0, no PRE gap.
REQ-034 en dropped mid-frame -> frame completes, busy falls after last GAP slot, data stays 0.
REQ-035 rst pulsed mid-slot -> data 0 in the same cycle, outputs at reset values, restart with PRE.
REQ-036 Macro defined, bright=127, byte 8'hFF -> transmitted 8'h7F; bright=255 -> 8'hFF.
